pvtmon_drp_poller: RTL and testbench

//  Upstream feeder of the pvtmon AXI-lite register slave. Round-robin polls XADC/SYSMON DRP

---
 rtl/pvtmon_pkg.sv | 49 ++++
 rtl/pvtmon_interval_timer.sv | 30 +++
 rtl/pvtmon_drp_poller.sv | 141 ++++++++++++++
 tb/tb_pvtmon_drp_poller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvtmon_pkg.sv
// Shared definitions for the pvtmon DRP poller.
//   - FSM state encoding
//   - power_status word layout (as a packed struct plus bit positions)
//   - default XADC/SYSMON DRP address table, byte i = channel i
//     ([6:0] DRP address, [7] = channel disabled)
package pvtmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_REQ,
        ST_WAIT,
        ST_NEXT
    } state_t;

    localparam int DATA_LSB  = 0;
    localparam int SEQ_LSB   = 16;
    localparam int TO_BIT    = 30;
    localparam int VALID_BIT = 31;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic        valid;
        logic        timed_out;
        logic [5:0]  rsvd;
        logic [7:0]  seq;
        logic [15:0] data;
    } status_word_t;

    localparam logic [7:0] ADDR_TEMP    = 8'h00;
    localparam logic [7:0] ADDR_VCCINT  = 8'h01;
    localparam logic [7:0] ADDR_VCCAUX  = 8'h02;
    localparam logic [7:0] ADDR_VCCBRAM = 8'h06;
    localparam logic [7:0] ADDR_VCCPINT = 8'h0D;
    localparam logic [7:0] ADDR_VCCPAUX = 8'h0E;
    localparam logic [7:0] ADDR_VCCODDR = 8'h0F;
    localparam logic [7:0] ADDR_VAUX0   = 8'h10;

    localparam int DEF_NUM_CHAN = 13;

    // Channel 0 sits in the least significant byte.
    localparam logic [DEF_NUM_CHAN*8-1:0] DEF_CHAN_ADDRS = {
        ADDR_VAUX0 + 8'd5, ADDR_VAUX0 + 8'd4, ADDR_VAUX0 + 8'd3,
        ADDR_VAUX0 + 8'd2, ADDR_VAUX0 + 8'd1, ADDR_VAUX0,
        ADDR_VCCODDR, ADDR_VCCPAUX, ADDR_VCCPINT, ADDR_VCCBRAM,
        ADDR_VCCAUX, ADDR_VCCINT, ADDR_TEMP
    };

endpackage

// File: rtl/pvtmon_interval_timer.sv
// Loadable down-counter that holds at zero.
//   clk, rst_n : clock, async active-low reset (reset loads LOAD_VAL)
//   load       : reload LOAD_VAL (wins over dec)
//   dec        : decrement by one unless already zero
//   done       : counter is zero
module pvtmon_interval_timer #(
    parameter int           W        = 32,
    parameter logic [W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= LOAD_VAL;
        else if (load)
            cnt <= LOAD_VAL;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pvtmon_drp_poller.sv
// Round-robin DRP poller feeding the pvtmon register slave. Each enabled
// channel is read once per sweep and its result packed into one 32-bit word
// of power_status. Runs on S_AXI_ACLK, so power_status needs no CDC.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   enable                    : permit new sweeps (a running sweep always completes)
//   drp_*                     : DRP master, read-only (dwe/di tied 0)
//   power_status              : word i = status of channel i
//   sweep_done                : 1-cycle pulse at the end of each sweep
//   timeout_count             : saturating count of abandoned DRP reads
module pvtmon_drp_poller
    import pvtmon_pkg::*;
#(
    parameter int                         NUM_POWER_REG = 13,
    parameter logic [NUM_POWER_REG*8-1:0] CHAN_ADDRS    = DEF_CHAN_ADDRS,
    parameter logic [31:0]                POLL_INTERVAL = 32'd1_000_000,
    parameter logic [7:0]                 DRP_TIMEOUT   = 8'd255
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         enable,
    output logic                         drp_den,
    output logic                         drp_dwe,
    output logic [6:0]                   drp_daddr,
    output logic [15:0]                  drp_di,
    input  logic [15:0]                  drp_do,
    input  logic                         drp_drdy,
    output logic [NUM_POWER_REG*32-1:0]  power_status,
    output logic                         sweep_done,
    output logic [15:0]                  timeout_count
);

    localparam int IDX_W = (NUM_POWER_REG > 1) ? $clog2(NUM_POWER_REG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POWER_REG - 1);

    state_t         state;
    logic [IDX_W-1:0] idx;
    logic [7:0]     timer;
    logic           ivl_done;
    logic           ivl_load;
    logic           ivl_dec;
    logic           timer_expired;
    logic [7:0]     chan_tbl [NUM_POWER_REG];
    logic [7:0]     cur_byte;
    status_word_t   words    [NUM_POWER_REG];

    assign drp_dwe = 1'b0;
    assign drp_di  = '0;

    for (genvar g = 0; g < NUM_POWER_REG; g++) begin : g_chan
        assign chan_tbl[g]              = CHAN_ADDRS[g*8 +: 8];
        assign power_status[g*32 +: 32] = words[g];
    end

    assign cur_byte = chan_tbl[idx];

    // timer counts WAIT cycles already spent; the read is abandoned once
    // DRP_TIMEOUT WAIT cycles have gone by without drdy.
    assign timer_expired = ({1'b0, timer} + 9'd1) >= {1'b0, DRP_TIMEOUT};

    assign ivl_dec  = (state == ST_IDLE);
    assign ivl_load = (state == ST_NEXT) && (idx == LAST_IDX);

    pvtmon_interval_timer #(
        .W        (32),
        .LOAD_VAL (POLL_INTERVAL)
    ) u_ivl (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .load  (ivl_load),
        .dec   (ivl_dec),
        .done  (ivl_done)
    );

    // Every field of a word is written on the same edge, so the register
    // slave never observes a partially updated word.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= ST_IDLE;
            idx           <= '0;
            timer         <= '0;
            drp_den       <= 1'b0;
            drp_daddr     <= '0;
            sweep_done    <= 1'b0;
            timeout_count <= '0;
            for (int i = 0; i < NUM_POWER_REG; i++)
                words[i] <= '0;
        end else begin
            drp_den    <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ivl_done && enable) begin
                        idx   <= '0;
                        state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (cur_byte[7]) begin
                        state <= ST_NEXT;
                    end else begin
                        drp_den   <= 1'b1;
                        drp_daddr <= cur_byte[6:0];
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // drdy has priority over a coinciding timeout.
                    if (drp_drdy) begin
                        words[idx].data      <= drp_do;
                        words[idx].seq       <= words[idx].seq + 8'd1;
                        words[idx].valid     <= 1'b1;
                        words[idx].timed_out <= 1'b0;
                        state                <= ST_NEXT;
                    end else if (timer_expired) begin
                        words[idx].timed_out <= 1'b1;
                        if (timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                        state <= ST_NEXT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_NEXT: begin
                    if (idx == LAST_IDX) begin
                        sweep_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SEL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pvtmon_drp_poller.sv
// Directed bench for pvtmon_drp_poller: POLL_INTERVAL=4, DRP_TIMEOUT=8,
// channel 5 disabled. The DRP model answers one cycle into WAIT with
// 0x1000+addr, unless the address is muted.
module tb_pvtmon_drp_poller;

    localparam int N = 13;
    localparam logic [N*8-1:0] TB_ADDRS = {
        8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10,
        8'h0F, 8'h80, 8'h0D, 8'h06, 8'h02, 8'h01, 8'h00
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          drp_den;
    logic          drp_dwe;
    logic [6:0]    drp_daddr;
    logic [15:0]   drp_di;
    logic [15:0]   drp_do = '0;
    logic          drp_drdy = 1'b0;
    logic [N*32-1:0] power_status;
    logic          sweep_done;
    logic [15:0]   timeout_count;

    int checks = 0;
    int failures = 0;

    pvtmon_drp_poller #(
        .NUM_POWER_REG (N),
        .CHAN_ADDRS    (TB_ADDRS),
        .POLL_INTERVAL (32'd4),
        .DRP_TIMEOUT   (8'd8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .enable        (enable),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .drp_di        (drp_di),
        .drp_do        (drp_do),
        .drp_drdy      (drp_drdy),
        .power_status  (power_status),
        .sweep_done    (sweep_done),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    // cycle counter and DUT-output monitor
    int cyc = 0;
    int sweep_cnt = 0;
    int den_cnt = 0;
    int den_cyc [128];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sweep_done) sweep_cnt <= sweep_cnt + 1;
        if (drp_den) begin
            den_cnt <= den_cnt + 1;
            den_cyc[drp_daddr] <= cyc;
        end
    end

    // DRP model
    logic [6:0] mute_addr    = 7'h7F;
    logic       stray_at_den = 1'b0;
    logic [6:0] stray_addr   = 7'h7F;
    logic       stray_idle   = 1'b0;
    logic       m_pend       = 1'b0;
    logic [6:0] m_addr       = '0;

    always @(negedge clk) begin
        drp_drdy = 1'b0;
        if (!rst_n) begin
            m_pend = 1'b0;
        end else if (drp_den) begin
            m_addr = drp_daddr;
            m_pend = (drp_daddr != mute_addr);
            if (stray_at_den && drp_daddr == stray_addr) begin
                drp_drdy = 1'b1;
                drp_do   = 16'hDEAD;
            end
        end else if (m_pend) begin
            m_pend   = 1'b0;
            drp_drdy = 1'b1;
            drp_do   = 16'h1000 + {9'd0, m_addr};
        end else if (stray_idle) begin
            drp_drdy = 1'b1;
            drp_do   = 16'hBEEF;
        end
    end

    function automatic logic [31:0] w(input int i);
        return power_status[i*32 +: 32];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_sweeps(input int n, input int budget, output bit ok);
        int base;
        base = sweep_cnt;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (sweep_cnt >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_den(input logic [6:0] addr, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (drp_den && drp_daddr == addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (drp_den !== 1'b0) begin failures++; $display("FAIL rst_den got=%b exp=0", drp_den); end
        checks++; if (power_status !== '0) begin failures++; $display("FAIL rst_status got=%h exp=0", power_status); end
        checks++; if (timeout_count !== 16'h0) begin failures++; $display("FAIL rst_tocnt got=%h exp=0", timeout_count); end
        checks++; if ({sweep_done, drp_dwe, drp_di} !== 18'h0) begin failures++; $display("FAIL rst_misc got=%h exp=0", {sweep_done, drp_dwe, drp_di}); end
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (drp_den) break;
        end
        // 4 decrements, 1 IDLE->SEL, 1 SEL->REQ
        checks++; if (n !== 6) begin failures++; $display("FAIL rst_first_den_cycles got=%0d exp=6", n); end
        checks++; if (drp_daddr !== 7'h00) begin failures++; $display("FAIL rst_first_addr got=%h exp=00", drp_daddr); end
    endtask

    task automatic test_basic_sweep();
        bit ok;
        wait_sweeps(1, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_sweep_timeout got=%b exp=1", ok); end
        checks++; if (w(0) !== 32'h8001_1000) begin failures++; $display("FAIL basic_word0 got=%h exp=80011000", w(0)); end
        checks++; if (w(3) !== 32'h8001_1006) begin failures++; $display("FAIL basic_word3 got=%h exp=80011006", w(3)); end
        checks++; if (w(12) !== 32'h8001_1015) begin failures++; $display("FAIL basic_word12 got=%h exp=80011015", w(12)); end
        checks++; if (sweep_cnt !== 1) begin failures++; $display("FAIL basic_sweep_pulses got=%0d exp=1", sweep_cnt); end
        checks++; if (sweep_done !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", sweep_done); end
        checks++; if (den_cyc[1] - den_cyc[0] !== 4) begin failures++; $display("FAIL basic_den_gap got=%0d exp=4", den_cyc[1] - den_cyc[0]); end
    endtask

    task automatic test_timeout();
        bit ok;
        mute_addr = 7'h02;
        do_reset();
        wait_sweeps(1, 300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL to_sweep_timeout got=%b exp=1", ok); end
        checks++; if (w(2) !== 32'h4000_0000) begin failures++; $display("FAIL to_word2 got=%h exp=40000000", w(2)); end
        checks++; if (w(1) !== 32'h8001_1001) begin failures++; $display("FAIL to_word1 got=%h exp=80011001", w(1)); end
        checks++; if (timeout_count !== 16'd1) begin failures++; $display("FAIL to_count1 got=%0d exp=1", timeout_count); end
        checks++; if (den_cyc[6] - den_cyc[2] !== 11) begin failures++; $display("FAIL to_den_gap got=%0d exp=11", den_cyc[6] - den_cyc[2]); end
        wait_sweeps(1, 300, ok);
        checks++; if (timeout_count !== 16'd2) begin failures++; $display("FAIL to_count2 got=%0d exp=2", timeout_count); end
    endtask

    task automatic test_late_drdy();
        bit ok;
        // currently in IDLE right after a sweep: stray drdy here must be ignored
        stray_idle = 1'b1;
        @(posedge clk); #1 stray_idle = 1'b0;
        checks++; if (w(0) !== 32'h8002_1000) begin failures++; $display("FAIL late_idle_word0 got=%h exp=80021000", w(0)); end
        // stray drdy during ch3 REQ, right after the ch2 timeout
        stray_addr   = 7'h06;
        stray_at_den = 1'b1;
        wait_sweeps(1, 300, ok);
        stray_at_den = 1'b0;
        checks++; if (w(3) !== 32'h8003_1006) begin failures++; $display("FAIL late_word3 got=%h exp=80031006", w(3)); end
        checks++; if (w(2) !== 32'h4000_0000) begin failures++; $display("FAIL late_word2 got=%h exp=40000000", w(2)); end
        checks++; if (timeout_count !== 16'd3) begin failures++; $display("FAIL late_count got=%0d exp=3", timeout_count); end
        mute_addr = 7'h7F;
    endtask

    task automatic test_disabled_chan();
        bit ok;
        int base;
        do_reset();
        base = den_cnt;
        wait_sweeps(3, 600, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dis_sweep_timeout got=%b exp=1", ok); end
        checks++; if (w(5) !== 32'h0) begin failures++; $display("FAIL dis_word5 got=%h exp=0", w(5)); end
        checks++; if (w(0) !== 32'h8003_1000) begin failures++; $display("FAIL dis_word0 got=%h exp=80031000", w(0)); end
        checks++; if (w(6) !== 32'h8003_100F) begin failures++; $display("FAIL dis_word6 got=%h exp=8003100f", w(6)); end
        checks++; if (den_cnt - base !== 36) begin failures++; $display("FAIL dis_den_count got=%0d exp=36", den_cnt - base); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int base_sw, base_den;
        wait_den(7'h0D, 300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL en_find_ch4 got=%b exp=1", ok); end
        enable  = 1'b0;
        base_sw = sweep_cnt;
        wait_sweeps(1, 300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL en_sweep_finish got=%b exp=1", ok); end
        base_den = den_cnt;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (den_cnt - base_den !== 0) begin failures++; $display("FAIL en_den_after got=%0d exp=0", den_cnt - base_den); end
        checks++; if (sweep_cnt - base_sw !== 1) begin failures++; $display("FAIL en_sweep_pulses got=%0d exp=1", sweep_cnt - base_sw); end
        checks++; if (w(4) !== 32'h8004_100D) begin failures++; $display("FAIL en_word4 got=%h exp=8004100d", w(4)); end
        enable = 1'b1;
    endtask

    task automatic test_seq_wrap();
        bit ok;
        do_reset();
        wait_sweeps(255, 255 * 80, ok);
        checks++; if (w(0) !== 32'h80FF_1000) begin failures++; $display("FAIL wrap_word0_255 got=%h exp=80ff1000", w(0)); end
        wait_sweeps(1, 100, ok);
        checks++; if (w(0) !== 32'h8000_1000) begin failures++; $display("FAIL wrap_word0_256 got=%h exp=80001000", w(0)); end
        checks++; if (w(12) !== 32'h8000_1015) begin failures++; $display("FAIL wrap_word12_256 got=%h exp=80001015", w(12)); end
    endtask

    task automatic test_async_reset();
        bit ok;
        mute_addr = 7'h02;
        do_reset();
        wait_sweeps(1, 300, ok);
        checks++; if (timeout_count !== 16'd1) begin failures++; $display("FAIL ar_pre_count got=%0d exp=1", timeout_count); end
        mute_addr = 7'h7F;
        wait_den(7'h06, 300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ar_find_ch3 got=%b exp=1", ok); end
        rst_n = 1'b0;
        #1;
        checks++; if (drp_den !== 1'b0) begin failures++; $display("FAIL ar_den got=%b exp=0", drp_den); end
        checks++; if (power_status !== '0) begin failures++; $display("FAIL ar_status got=%h exp=0", power_status); end
        checks++; if (timeout_count !== 16'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", timeout_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_sweeps(1, 300, ok);
        checks++; if (w(2) !== 32'h8001_1002) begin failures++; $display("FAIL ar_resume_word2 got=%h exp=80011002", w(2)); end
        checks++; if (w(0) !== 32'h8001_1000) begin failures++; $display("FAIL ar_resume_word0 got=%h exp=80011000", w(0)); end
        checks++; if (timeout_count !== 16'd0) begin failures++; $display("FAIL ar_resume_count got=%0d exp=0", timeout_count); end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_timeout();
        test_late_drdy();
        test_disabled_chan();
        test_enable_drop();
        test_seq_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
